// File: rtl/avalon_debounce_pio_pkg.sv
// Shared constants for the debounced pushbutton/DIP-switch PIO:
// register word addresses, edge-capture selections and bus read latency.
package avalon_debounce_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int RD_LATENCY = 1;

  // Edge event for one bit given its current and one-cycle-old debounced value.
  function automatic logic edge_event(input int etype, input logic cur, input logic prev);
    logic ev;
    case (etype)
      EDGE_RISE: ev = cur & ~prev;
      EDGE_FALL: ev = ~cur & prev;
      default:   ev = cur ^ prev;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/avalon_debounce_pio_debounce_bit.sv
// One input bit: 2-FF synchroniser, 3-deep tick-sampled history and the
// debounced output. The output only moves when three consecutive tick
// samples agree, so glitches shorter than two tick periods never pass.
module avalon_debounce_pio_debounce_bit (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic pad,
  output logic deb
);

  logic       sync_q1;
  logic       sync_q2;
  logic [2:0] hist;
  logic [2:0] hist_next;

  assign hist_next = {hist[1:0], sync_q2};

  // Two-flop synchroniser for the raw asynchronous pad.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= pad;
      sync_q2 <= sync_q1;
    end
  end

  // On each tick shift in a sample; deb follows once the shifted history agrees.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= 3'b000;
      deb  <= 1'b0;
    end else if (tick) begin
      hist <= hist_next;
      if ((&hist_next) && !deb) begin
        deb <= 1'b1;
      end else if (!(|hist_next) && deb) begin
        deb <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/avalon_debounce_pio.sv
// Avalon-MM responder for board pushbuttons/DIP switches: debounced input
// data, per-bit edge capture with write-1-to-clear, optional level irq.
// Macro AVALON_DEBOUNCE_PIO_IRQ_EN enables the IRQMASK register and irq;
// without it irq is tied low and IRQMASK reads 0 (EDGECAP still works for polling).
module avalon_debounce_pio
  import avalon_debounce_pio_pkg::*;
#(
  parameter int DATA_W          = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pad_in,
  input  logic              chipselect,
  input  logic [1:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid,
  output logic              irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0]  presc_cnt;
  logic              tick;
  logic [DATA_W-1:0] deb;
  logic [DATA_W-1:0] deb_d;
  logic [DATA_W-1:0] ev;
  logic [DATA_W-1:0] cap;
  logic [DATA_W-1:0] clr;
  logic [DATA_W-1:0] mask;
  logic              wr_en;
  logic              rd_en;
  logic [31:0]       rd_mux;
  logic              unused_wdata;

  // Upper writedata bits have no destination when DATA_W < 32.
  assign unused_wdata = ^writedata;

  // Free-running prescaler; tick marks the last count of each period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_cnt <= '0;
    end else if (presc_cnt == CNT_LAST) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + CNT_W'(1);
    end
  end

  assign tick = (presc_cnt == CNT_LAST);

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    avalon_debounce_pio_debounce_bit u_deb (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .pad   (pad_in[i]),
      .deb   (deb[i])
    );
    assign ev[i] = edge_event(EDGE_TYPE, deb[i], deb_d[i]);
  end

  // Write has priority: a simultaneous read is dropped and gets no valid pulse.
  assign wr_en = chipselect & write;
  assign rd_en = chipselect & read & ~write;
  assign clr   = (wr_en && (address == ADDR_EDGECAP)) ? writedata[DATA_W-1:0] : '0;

  // Delayed debounced copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_d <= '0;
    end else begin
      deb_d <= deb;
    end
  end

  // Edge capture; a new event beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap <= '0;
    end else begin
      cap <= ev | (cap & ~clr);
    end
  end

`ifdef AVALON_DEBOUNCE_PIO_IRQ_EN
  // Interrupt mask register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask <= '0;
    end else if (wr_en && (address == ADDR_IRQMASK)) begin
      mask <= writedata[DATA_W-1:0];
    end
  end

  // Registered level interrupt, one cycle behind the capture register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(cap & mask);
    end
  end
`else
  assign mask = '0;
  assign irq  = 1'b0;
`endif

  // Read data select, zero-extended to the bus width.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[DATA_W-1:0] = deb;
      ADDR_IRQMASK: rd_mux[DATA_W-1:0] = mask;
      ADDR_EDGECAP: rd_mux[DATA_W-1:0] = cap;
      default:      rd_mux = '0;
    endcase
  end

  // Registered read response; readdata holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= rd_en;
      if (rd_en) begin
        readdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_avalon_debounce_pio.sv
// Directed bench for avalon_debounce_pio (DATA_W=4, DEBOUNCE_CYCLES=4, falling edges).
module tb_avalon_debounce_pio;
  import avalon_debounce_pio_pkg::*;

`ifdef AVALON_DEBOUNCE_PIO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  pad_in;
  logic        chipselect;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        irq;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  avalon_debounce_pio #(
    .DATA_W          (4),
    .DEBOUNCE_CYCLES (4),
    .EDGE_TYPE       (EDGE_FALL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pad_in        (pad_in),
    .chipselect    (chipselect),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .irq           (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    read       = 1'b0;
    address    = a;
    writedata  = d;
    step();
    idle();
  endtask

  task automatic do_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
    chipselect = 1'b1;
    read       = 1'b1;
    write      = 1'b0;
    address    = a;
    chk({tag, "_rdv_before"}, 32'(readdatavalid), 32'd0);
    step();
    chk({tag, "_rdv"}, 32'(readdatavalid), 32'd1);
    chk({tag, "_data"}, readdata, exp);
    idle();
    step();
    chk({tag, "_rdv_drop"}, 32'(readdatavalid), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_mask2;
    logic        found;
    logic        prev_irq;
    logic        irq_at_set;
    logic [31:0] rd_at_set;
    logic        hit;
    int          tk;

    exp_mask2 = IRQ_ON ? 32'h2 : 32'h0;
    reset     = 1'b1;
    pad_in    = 4'hF;
    address   = 2'd0;
    writedata = 32'h0;
    idle();
    step();
    step();
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_rdv", 32'(readdatavalid), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    repeat (20) step();

    do_write(ADDR_IRQMASK, 32'h2);
    do_read(ADDR_IRQMASK, exp_mask2, "mask_rd");
    do_read(ADDR_DATA, 32'hF, "data_init");
    chk("irq_init", 32'(irq), 32'd0);
    do_read(ADDR_EDGECAP, 32'h0, "cap_init");
    do_write(ADDR_RSVD, 32'hFFFF_FFFF);
    do_write(ADDR_DATA, 32'h0);
    do_read(ADDR_RSVD, 32'h0, "rsvd_rd");
    do_read(ADDR_DATA, 32'hF, "data_ro");

    // short glitch on bit 0 must be rejected
    pad_in = 4'hE;
    repeat (5) step();
    pad_in = 4'hF;
    repeat (20) step();
    do_read(ADDR_DATA, 32'hF, "glitch_data");
    do_read(ADDR_EDGECAP, 32'h0, "glitch_cap");

    // stable press on bit 1; poll EDGECAP every cycle
    pad_in     = 4'hD;
    found      = 1'b0;
    prev_irq   = irq;
    irq_at_set = 1'b0;
    rd_at_set  = 32'h0;
    tk         = 0;
    chipselect = 1'b1;
    read       = 1'b1;
    address    = ADDR_EDGECAP;
    for (int i = 0; i < 40; i++) begin
      step();
      if (readdata[1]) begin
        found      = 1'b1;
        irq_at_set = irq;
        rd_at_set  = readdata;
        tk         = (cyc - 2) % 4;
        break;
      end
      prev_irq = irq;
    end
    idle();
    step();
    chk("press_found", 32'(found), 32'd1);
    chk("press_cap_val", rd_at_set, 32'h2);
    chk("irq_before_set", 32'(prev_irq), 32'd0);
    chk("irq_lag", 32'(irq_at_set), 32'(IRQ_ON));
    do_read(ADDR_DATA, 32'hD, "press_data");
    do_read(ADDR_EDGECAP, 32'h2, "press_cap");

    // write-1-to-clear, irq follows one cycle later
    chipselect = 1'b1;
    write      = 1'b1;
    address    = ADDR_EDGECAP;
    writedata  = 32'h2;
    step();
    idle();
    chk("irq_hold_at_clr", 32'(irq), 32'(IRQ_ON));
    step();
    chk("irq_fall", 32'(irq), 32'd0);
    do_read(ADDR_EDGECAP, 32'h0, "clr_cap");

    // release (rising, not captured), then press with a clear on the set edge
    pad_in = 4'hF;
    repeat (24) step();
    do_read(ADDR_EDGECAP, 32'h0, "release_cap");
    pad_in = 4'hD;
    hit    = 1'b0;
    for (int n = 0; n < 12; n++) begin
      while ((cyc % 4) != tk) step();
      chipselect = 1'b1;
      write      = 1'b1;
      read       = 1'b0;
      address    = ADDR_EDGECAP;
      writedata  = 32'h2;
      step();
      write = 1'b0;
      read  = 1'b1;
      step();
      idle();
      if (readdata[1]) begin
        hit = 1'b1;
        break;
      end
    end
    step();
    chk("set_wins_clear", 32'(hit), 32'd1);

    // back-to-back reads of 0, 2, 3
    chipselect = 1'b1;
    read       = 1'b1;
    address    = ADDR_DATA;
    step();
    chk("b2b_rdv0", 32'(readdatavalid), 32'd1);
    chk("b2b_data0", readdata, 32'hD);
    address = ADDR_IRQMASK;
    step();
    chk("b2b_rdv2", 32'(readdatavalid), 32'd1);
    chk("b2b_data2", readdata, exp_mask2);
    address = ADDR_EDGECAP;
    step();
    chk("b2b_rdv3", 32'(readdatavalid), 32'd1);
    chk("b2b_data3", readdata, 32'h2);
    idle();
    step();
    chk("b2b_rdv_end", 32'(readdatavalid), 32'd0);
    chk("b2b_hold", readdata, 32'h2);

    // read and write together: write only
    chipselect = 1'b1;
    read       = 1'b1;
    write      = 1'b1;
    address    = ADDR_IRQMASK;
    writedata  = 32'h5;
    step();
    idle();
    chk("rw_no_rdv", 32'(readdatavalid), 32'd0);
    chk("rw_hold", readdata, 32'h2);
    do_read(ADDR_IRQMASK, IRQ_ON ? 32'h5 : 32'h0, "rw_mask");

    // chipselect low: ignored
    chipselect = 1'b0;
    write      = 1'b1;
    address    = ADDR_IRQMASK;
    writedata  = 32'hA;
    step();
    address = ADDR_EDGECAP;
    writedata = 32'hF;
    step();
    write = 1'b0;
    read  = 1'b1;
    step();
    chk("nocs_rdv", 32'(readdatavalid), 32'd0);
    idle();
    do_read(ADDR_IRQMASK, IRQ_ON ? 32'h5 : 32'h0, "nocs_mask");
    do_read(ADDR_EDGECAP, 32'h2, "nocs_cap");

    // reset in the middle of a read response
    do_write(ADDR_IRQMASK, 32'h2);
    step();
    chk("irq_pre_reset", 32'(irq), 32'(IRQ_ON));
    chipselect = 1'b1;
    read       = 1'b1;
    address    = ADDR_DATA;
    step();
    chk("midrd_rdv", 32'(readdatavalid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_rdv", 32'(readdatavalid), 32'd0);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", 32'(irq), 32'd0);
    idle();
    step();
    step();
    reset = 1'b0;
    do_read(ADDR_DATA, 32'h0, "post_rst_data");
    do_read(ADDR_IRQMASK, 32'h0, "post_rst_mask");
    do_read(ADDR_EDGECAP, 32'h0, "post_rst_cap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
